// File: rtl/riscv_pkg.sv
// Shared RISC-V front-end types and constants used by the fetch stage.
package riscv_pkg;
  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] PC_STEP   = 32'h0000_0004;
  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [0:0] {
    RUN   = 1'b0,
    DRAIN = 1'b1
  } fetch_state_t;
endpackage

// File: rtl/fetch_fifo.sv
// Shift-register FIFO of {pc, instr}; entry 0 is the head, so head outputs come straight from flops.
module fetch_fifo
  import riscv_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_flush,
  input  logic             i_push,
  input  logic [XLEN-1:0]  i_push_pc,
  input  logic [XLEN-1:0]  i_push_instr,
  input  logic             i_pop,
  output logic             o_valid,
  output logic [XLEN-1:0]  o_pc,
  output logic [XLEN-1:0]  o_instr,
  output logic [CNT_W-1:0] o_count
);

  logic [XLEN-1:0]  r_pc       [DEPTH];
  logic [XLEN-1:0]  r_instr    [DEPTH];
  logic [XLEN-1:0]  w_next_pc  [DEPTH];
  logic [XLEN-1:0]  w_next_instr [DEPTH];
  logic [CNT_W-1:0] r_count;
  logic [CNT_W-1:0] w_wr_idx;

  // A simultaneous pop shifts everything down first, so the write lands one slot lower.
  assign w_wr_idx = r_count - CNT_W'(i_pop);

  for (genvar g = 0; g < DEPTH; g++) begin : g_shift
    if (g < DEPTH - 1) begin : g_mid
      assign w_next_pc[g]    = r_pc[g+1];
      assign w_next_instr[g] = r_instr[g+1];
    end else begin : g_last
      assign w_next_pc[g]    = r_pc[g];
      assign w_next_instr[g] = r_instr[g];
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_count <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_pc[i]    <= '0;
        r_instr[i] <= '0;
      end
    end else begin
      if (i_flush) r_count <= '0;
      else         r_count <= r_count + CNT_W'(i_push) - CNT_W'(i_pop);
      for (int i = 0; i < DEPTH; i++) begin
        if (i_push && !i_flush && (w_wr_idx == CNT_W'(i))) begin
          r_pc[i]    <= i_push_pc;
          r_instr[i] <= i_push_instr;
        end else if (i_pop && !i_flush) begin
          r_pc[i]    <= w_next_pc[i];
          r_instr[i] <= w_next_instr[i];
        end
      end
    end
  end

  assign o_valid = (r_count != '0);
  assign o_pc    = r_pc[0];
  assign o_instr = r_instr[0];
  assign o_count = r_count;

endmodule

// File: rtl/instr_fetch.sv
// Fetch stage: credit-limited in-order requests, response FIFO, redirect flush with in-flight drain.
// Optional macro IF_MISALIGN_CHECK_EN turns a misaligned redirect into a sticky fetch fault.
module instr_fetch
  import riscv_pkg::*;
#(
  parameter int              DEPTH    = 2,
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            redirect_i,
  input  logic [XLEN-1:0] redirect_pc_i,
  output logic            imem_req_o,
  output logic [XLEN-1:0] imem_addr_o,
  input  logic            imem_gnt_i,
  input  logic            imem_rvalid_i,
  input  logic [XLEN-1:0] imem_rdata_i,
  output logic            instr_valid_o,
  output logic [XLEN-1:0] instr_o,
  output logic [XLEN-1:0] instr_pc_o,
  input  logic            instr_ready_i,
  output logic            fetch_fault_o
);

  localparam int CNT_W = $clog2(DEPTH + 1);

  fetch_state_t     r_state, w_state_next;
  logic [XLEN-1:0]  r_fetch_addr, r_resp_pc, w_target;
  logic [CNT_W-1:0] r_outstanding, w_outstanding_next;
  logic [CNT_W-1:0] r_discard_cnt, w_discard_next;
  logic [CNT_W-1:0] w_occ;
  logic [CNT_W:0]   w_credit_used;
  logic             w_fault, w_req_raw, w_grant, w_push, w_pop, w_fifo_valid;

  `ifdef IF_MISALIGN_CHECK_EN
  logic r_fault;
  always_ff @(posedge clk) begin
    if (!reset)          r_fault <= 1'b0;
    else if (redirect_i) r_fault <= |redirect_pc_i[1:0];
  end
  assign w_fault  = r_fault;
  assign w_target = redirect_pc_i;
  `else
  logic w_unused_pc_lsbs;
  assign w_unused_pc_lsbs = ^redirect_pc_i[1:0];
  assign w_fault  = 1'b0;
  assign w_target = {redirect_pc_i[XLEN-1:2], 2'b00};
  `endif

  assign w_pop = instr_ready_i && w_fifo_valid && !redirect_i;

  // Counting this cycle's pop as freed space keeps single-cycle memory at one instruction per cycle.
  assign w_credit_used = {1'b0, w_occ} + {1'b0, r_outstanding} - (CNT_W+1)'(w_pop);
  assign w_req_raw     = (r_state == RUN) && !w_fault && (w_credit_used < (CNT_W+1)'(DEPTH));
  assign imem_req_o    = w_req_raw && !redirect_i && reset;
  assign imem_addr_o   = r_fetch_addr;

  // In a redirect cycle any grant is treated as an in-flight request that must be drained.
  assign w_grant = redirect_i ? imem_gnt_i : (imem_req_o && imem_gnt_i);
  assign w_push  = imem_rvalid_i && (r_state == RUN) && !redirect_i;
  assign w_outstanding_next = r_outstanding + CNT_W'(w_grant) - CNT_W'(imem_rvalid_i);

  always_comb begin
    w_state_next   = r_state;
    w_discard_next = r_discard_cnt;
    if (redirect_i) begin
      w_discard_next = w_outstanding_next;
      w_state_next   = (w_outstanding_next != '0) ? DRAIN : RUN;
    end else begin
      case (r_state)
        DRAIN: begin
          if (imem_rvalid_i) w_discard_next = r_discard_cnt - CNT_W'(1);
          if (w_discard_next == '0) w_state_next = RUN;
        end
        default: w_state_next = RUN;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state       <= RUN;
      r_fetch_addr  <= RESET_PC;
      r_resp_pc     <= RESET_PC;
      r_outstanding <= '0;
      r_discard_cnt <= '0;
    end else begin
      r_state       <= w_state_next;
      r_outstanding <= w_outstanding_next;
      r_discard_cnt <= w_discard_next;
      if (redirect_i) begin
        r_fetch_addr <= w_target;
        r_resp_pc    <= w_target;
      end else begin
        if (imem_req_o && imem_gnt_i) r_fetch_addr <= r_fetch_addr + PC_STEP;
        if (w_push)                   r_resp_pc    <= r_resp_pc + PC_STEP;
      end
    end
  end

  fetch_fifo #(
    .DEPTH (DEPTH),
    .CNT_W (CNT_W)
  ) u_fifo (
    .clk          (clk),
    .reset        (reset),
    .i_flush      (redirect_i),
    .i_push       (w_push),
    .i_push_pc    (r_resp_pc),
    .i_push_instr (imem_rdata_i),
    .i_pop        (w_pop),
    .o_valid      (w_fifo_valid),
    .o_pc         (instr_pc_o),
    .o_instr      (instr_o),
    .o_count      (w_occ)
  );

  assign instr_valid_o = w_fifo_valid;
  assign fetch_fault_o = w_fault;

endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch: directed scenarios plus a randomized run against a queue-based memory/decode model.
module tb_instr_fetch;
  localparam int          DEPTH    = 2;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        reset, redirect_i, imem_gnt_i, imem_rvalid_i, instr_ready_i;
  logic [31:0] redirect_pc_i, imem_rdata_i;
  logic        imem_req_o, instr_valid_o, fetch_fault_o;
  logic [31:0] imem_addr_o, instr_o, instr_pc_o;

  instr_fetch #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clk(clk), .reset(reset), .redirect_i(redirect_i), .redirect_pc_i(redirect_pc_i),
    .imem_req_o(imem_req_o), .imem_addr_o(imem_addr_o), .imem_gnt_i(imem_gnt_i),
    .imem_rvalid_i(imem_rvalid_i), .imem_rdata_i(imem_rdata_i),
    .instr_valid_o(instr_valid_o), .instr_o(instr_o), .instr_pc_o(instr_pc_o),
    .instr_ready_i(instr_ready_i), .fetch_fault_o(fetch_fault_o)
  );

  always #5 clk = ~clk;

  // memory model: in-order queue of granted requests; stale entries belong to a flushed stream
  logic [31:0] mq_addr[$];
  bit          mq_stale[$];
  int          mq_due[$];
  int          cyc, lat_min, lat_max, rv_pct;
  int          occ_m;
  logic [31:0] exp_pc, exp_fetch;
  int          n_checks = 0, n_errors = 0;

  function automatic logic [31:0] mem_data(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
  endfunction

  function automatic logic [31:0] align_tgt(input logic [31:0] t);
  `ifdef IF_MISALIGN_CHECK_EN
    return t;
  `else
    return {t[31:2], 2'b00};
  `endif
  endfunction

  task automatic do_reset();
    reset = 1'b0; redirect_i = 1'b0; redirect_pc_i = '0; imem_gnt_i = 1'b0;
    imem_rvalid_i = 1'b0; imem_rdata_i = '0; instr_ready_i = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    mq_addr.delete(); mq_stale.delete(); mq_due.delete();
    occ_m = 0; exp_pc = RESET_PC; exp_fetch = RESET_PC;
    lat_min = 1; lat_max = 1; rv_pct = 100;
    reset = 1'b1;
  endtask

  task automatic cycle_pre();
    if (mq_addr.size() > 0 && mq_due[0] <= cyc && int'($urandom_range(99)) < rv_pct) begin
      imem_rvalid_i = 1'b1;
      imem_rdata_i  = mem_data(mq_addr[0]);
    end else begin
      imem_rvalid_i = 1'b0;
      imem_rdata_i  = $urandom;
    end
    #1;
  endtask

  task automatic cycle_post();
    bit hs, pop_m, push_m;
    hs = imem_req_o && imem_gnt_i;
    if (redirect_i) begin
      foreach (mq_stale[i]) mq_stale[i] = 1'b1;
      occ_m = 0;
      exp_pc = align_tgt(redirect_pc_i);
      exp_fetch = align_tgt(redirect_pc_i);
    end else begin
      pop_m  = (occ_m > 0) && instr_ready_i;
      push_m = imem_rvalid_i && !mq_stale[0];
      occ_m  = occ_m + int'(push_m) - int'(pop_m);
      if (pop_m) exp_pc = exp_pc + 32'd4;
    end
    if (imem_rvalid_i) begin
      void'(mq_addr.pop_front()); void'(mq_stale.pop_front()); void'(mq_due.pop_front());
    end
    if (hs) begin
      mq_addr.push_back(imem_addr_o); mq_stale.push_back(1'b0);
      mq_due.push_back(cyc + int'($urandom_range(lat_max, lat_min)));
      exp_fetch = exp_fetch + 32'd4;
    end
    @(posedge clk);
    cyc++;
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b0; redirect_i = 1'b0; redirect_pc_i = 32'h1234_5677; imem_gnt_i = 1'b1;
    imem_rvalid_i = 1'b0; imem_rdata_i = '0; instr_ready_i = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk); #1;
    n_checks++; if (imem_req_o !== 1'b0) begin n_errors++; $display("FAIL reset_req: got %b expected 0", imem_req_o); end
    n_checks++; if (imem_addr_o !== RESET_PC) begin n_errors++; $display("FAIL reset_addr: got %h expected %h", imem_addr_o, RESET_PC); end
    n_checks++; if (instr_valid_o !== 1'b0) begin n_errors++; $display("FAIL reset_valid: got %b expected 0", instr_valid_o); end
    n_checks++; if (instr_o !== 32'h0) begin n_errors++; $display("FAIL reset_instr: got %h expected 0", instr_o); end
    n_checks++; if (instr_pc_o !== 32'h0) begin n_errors++; $display("FAIL reset_pc: got %h expected 0", instr_pc_o); end
    n_checks++; if (fetch_fault_o !== 1'b0) begin n_errors++; $display("FAIL reset_fault: got %b expected 0", fetch_fault_o); end
    do_reset();
    cycle_pre();
    n_checks++; if (imem_req_o !== 1'b1 || imem_addr_o !== RESET_PC) begin n_errors++; $display("FAIL first_req: got req=%b addr=%h expected req=1 addr=%h", imem_req_o, imem_addr_o, RESET_PC); end
    cycle_post();
  endtask

  task automatic test_stream();
    do_reset();
    imem_gnt_i = 1'b1; instr_ready_i = 1'b1;
    for (int k = 0; k < 12; k++) begin
      cycle_pre();
      n_checks++; if (imem_req_o !== 1'b1 || imem_addr_o !== 32'(4*k)) begin n_errors++; $display("FAIL stream_req k=%0d: got req=%b addr=%h expected req=1 addr=%h", k, imem_req_o, imem_addr_o, 32'(4*k)); end
      if (k >= 2) begin
        n_checks++; if (instr_valid_o !== 1'b1 || instr_pc_o !== 32'(4*(k-2)) || instr_o !== mem_data(32'(4*(k-2)))) begin n_errors++; $display("FAIL stream_out k=%0d: got v=%b pc=%h ins=%h expected v=1 pc=%h", k, instr_valid_o, instr_pc_o, instr_o, 32'(4*(k-2))); end
      end else begin
        n_checks++; if (instr_valid_o !== 1'b0) begin n_errors++; $display("FAIL stream_early k=%0d: got valid=%b expected 0", k, instr_valid_o); end
      end
      cycle_post();
    end
  endtask

  task automatic test_backpressure();
    int grants = 0;
    do_reset();
    imem_gnt_i = 1'b1; instr_ready_i = 1'b0;
    repeat (10) begin
      cycle_pre();
      if (imem_req_o && imem_gnt_i) grants++;
      cycle_post();
    end
    n_checks++; if (grants !== 2) begin n_errors++; $display("FAIL bp_grants: got %0d expected 2", grants); end
    cycle_pre();
    n_checks++; if (imem_req_o !== 1'b0) begin n_errors++; $display("FAIL bp_noreq: got %b expected 0", imem_req_o); end
    n_checks++; if (instr_valid_o !== 1'b1 || instr_pc_o !== 32'h0) begin n_errors++; $display("FAIL bp_head: got v=%b pc=%h expected v=1 pc=0", instr_valid_o, instr_pc_o); end
    cycle_post();
    instr_ready_i = 1'b1;
    cycle_pre();
    n_checks++; if (imem_req_o !== 1'b1 || imem_addr_o !== 32'h8) begin n_errors++; $display("FAIL bp_resume: got req=%b addr=%h expected req=1 addr=8", imem_req_o, imem_addr_o); end
    for (int k = 0; k < 3; k++) begin
      if (k > 0) cycle_pre();
      n_checks++; if (instr_valid_o !== 1'b1 || instr_pc_o !== 32'(4*k)) begin n_errors++; $display("FAIL bp_drain k=%0d: got v=%b pc=%h expected v=1 pc=%h", k, instr_valid_o, instr_pc_o, 32'(4*k)); end
      cycle_post();
    end
  endtask

  task automatic test_gnt_stall();
    do_reset();
    instr_ready_i = 1'b1; imem_gnt_i = 1'b0;
    for (int k = 0; k < 5; k++) begin
      cycle_pre();
      n_checks++; if (imem_req_o !== 1'b1 || imem_addr_o !== 32'h0) begin n_errors++; $display("FAIL stall_hold k=%0d: got req=%b addr=%h expected req=1 addr=0", k, imem_req_o, imem_addr_o); end
      cycle_post();
    end
    imem_gnt_i = 1'b1;
    cycle_pre(); cycle_post();
    imem_gnt_i = 1'b0;
    cycle_pre();
    n_checks++; if (imem_req_o !== 1'b1 || imem_addr_o !== 32'h4) begin n_errors++; $display("FAIL stall_adv: got req=%b addr=%h expected req=1 addr=4", imem_req_o, imem_addr_o); end
    cycle_post();
  endtask

  task automatic test_redirect_drain();
    bit done = 1'b0, got = 1'b0;
    do_reset();
    instr_ready_i = 1'b1; imem_gnt_i = 1'b0;
    redirect_i = 1'b1; redirect_pc_i = 32'h10;
    cycle_pre(); cycle_post();
    redirect_i = 1'b0; imem_gnt_i = 1'b1; lat_min = 5; lat_max = 5;
    cycle_pre();
    n_checks++; if (imem_addr_o !== 32'h10 || imem_req_o !== 1'b1) begin n_errors++; $display("FAIL rd_req0: got req=%b addr=%h expected req=1 addr=10", imem_req_o, imem_addr_o); end
    cycle_post();
    cycle_pre();
    n_checks++; if (imem_addr_o !== 32'h14 || imem_req_o !== 1'b1) begin n_errors++; $display("FAIL rd_req1: got req=%b addr=%h expected req=1 addr=14", imem_req_o, imem_addr_o); end
    cycle_post();
    imem_gnt_i = 1'b0; redirect_i = 1'b1; redirect_pc_i = 32'h100;
    cycle_pre();
    n_checks++; if (imem_req_o !== 1'b0) begin n_errors++; $display("FAIL rd_forced_low: got %b expected 0", imem_req_o); end
    cycle_post();
    redirect_i = 1'b0; imem_gnt_i = 1'b1; lat_min = 1; lat_max = 1;
    for (int i = 0; i < 20 && !done; i++) begin
      cycle_pre();
      if (mq_addr.size() > 0) begin
        n_checks++; if (imem_req_o !== 1'b0) begin n_errors++; $display("FAIL rd_drain_noreq: got %b expected 0", imem_req_o); end
      end else begin
        done = 1'b1;
        n_checks++; if (imem_req_o !== 1'b1 || imem_addr_o !== 32'h100) begin n_errors++; $display("FAIL rd_restart: got req=%b addr=%h expected req=1 addr=100", imem_req_o, imem_addr_o); end
      end
      cycle_post();
    end
    if (!done) begin n_checks++; n_errors++; $display("FAIL rd_drain_timeout: got pending=%0d expected 0", mq_addr.size()); end
    for (int i = 0; i < 10 && !got; i++) begin
      cycle_pre();
      if (instr_valid_o) begin
        got = 1'b1;
        n_checks++; if (instr_pc_o !== 32'h100 || instr_o !== mem_data(32'h100)) begin n_errors++; $display("FAIL rd_first_pc: got pc=%h ins=%h expected pc=100 ins=%h", instr_pc_o, instr_o, mem_data(32'h100)); end
      end
      cycle_post();
    end
    if (!got) begin n_checks++; n_errors++; $display("FAIL rd_valid_timeout: got valid=0 expected 1"); end
  endtask

  task automatic test_redirect_same_cycle();
    do_reset();
    imem_gnt_i = 1'b1; instr_ready_i = 1'b0;
    repeat (2) begin cycle_pre(); cycle_post(); end
    redirect_i = 1'b1; redirect_pc_i = 32'h40; imem_gnt_i = 1'b0; instr_ready_i = 1'b1;
    cycle_pre();
    n_checks++; if (instr_valid_o !== 1'b1 || instr_pc_o !== 32'h0) begin n_errors++; $display("FAIL sc_pre: got v=%b pc=%h expected v=1 pc=0", instr_valid_o, instr_pc_o); end
    cycle_post();
    redirect_i = 1'b0; imem_gnt_i = 1'b1;
    cycle_pre();
    n_checks++; if (instr_valid_o !== 1'b0) begin n_errors++; $display("FAIL sc_flush: got valid=%b expected 0", instr_valid_o); end
    n_checks++; if (imem_req_o !== 1'b1 || imem_addr_o !== 32'h40) begin n_errors++; $display("FAIL sc_req: got req=%b addr=%h expected req=1 addr=40", imem_req_o, imem_addr_o); end
    cycle_post();
    cycle_pre();
    n_checks++; if (instr_valid_o !== 1'b0) begin n_errors++; $display("FAIL sc_t2: got valid=%b expected 0", instr_valid_o); end
    cycle_post();
    cycle_pre();
    n_checks++; if (instr_valid_o !== 1'b1 || instr_pc_o !== 32'h40) begin n_errors++; $display("FAIL sc_t3: got v=%b pc=%h expected v=1 pc=40", instr_valid_o, instr_pc_o); end
    cycle_post();
  endtask

  task automatic test_misalign();
    do_reset();
    imem_gnt_i = 1'b0; instr_ready_i = 1'b1;
    redirect_i = 1'b1; redirect_pc_i = 32'h102;
    cycle_pre(); cycle_post();
    redirect_i = 1'b0; imem_gnt_i = 1'b1;
  `ifdef IF_MISALIGN_CHECK_EN
    for (int k = 0; k < 4; k++) begin
      cycle_pre();
      n_checks++; if (fetch_fault_o !== 1'b1 || imem_req_o !== 1'b0 || instr_valid_o !== 1'b0) begin n_errors++; $display("FAIL mis_fault k=%0d: got f=%b req=%b v=%b expected f=1 req=0 v=0", k, fetch_fault_o, imem_req_o, instr_valid_o); end
      cycle_post();
    end
    imem_gnt_i = 1'b0; redirect_i = 1'b1; redirect_pc_i = 32'h200;
    cycle_pre(); cycle_post();
    redirect_i = 1'b0; imem_gnt_i = 1'b1;
    cycle_pre();
    n_checks++; if (fetch_fault_o !== 1'b0 || imem_req_o !== 1'b1 || imem_addr_o !== 32'h200) begin n_errors++; $display("FAIL mis_clear: got f=%b req=%b addr=%h expected f=0 req=1 addr=200", fetch_fault_o, imem_req_o, imem_addr_o); end
    cycle_post();
  `else
    cycle_pre();
    n_checks++; if (fetch_fault_o !== 1'b0 || imem_req_o !== 1'b1 || imem_addr_o !== 32'h100) begin n_errors++; $display("FAIL mis_ignored: got f=%b req=%b addr=%h expected f=0 req=1 addr=100", fetch_fault_o, imem_req_o, imem_addr_o); end
    cycle_post();
    cycle_pre(); cycle_post();
    cycle_pre();
    n_checks++; if (instr_valid_o !== 1'b1 || instr_pc_o !== 32'h100) begin n_errors++; $display("FAIL mis_pc: got v=%b pc=%h expected v=1 pc=100", instr_valid_o, instr_pc_o); end
    cycle_post();
  `endif
  endtask

  task automatic test_random();
    int  pops = 0;
    bit  held = 1'b0;
    do_reset();
    lat_min = 1; lat_max = 4; rv_pct = 80;
    for (int k = 0; k < 3000; k++) begin
      instr_ready_i = ($urandom_range(99) < 75);
      redirect_i    = ($urandom_range(99) < 3);
      imem_gnt_i    = redirect_i ? 1'b0 : ($urandom_range(99) < 70);
    `ifdef IF_MISALIGN_CHECK_EN
      redirect_pc_i = $urandom & 32'hFFFF_FFFC;
    `else
      redirect_pc_i = $urandom;
    `endif
      if ($urandom_range(9) == 0) redirect_pc_i = 32'hFFFF_FFF0;
      cycle_pre();
      n_checks++; if (instr_valid_o !== (occ_m > 0)) begin n_errors++; $display("FAIL rnd_valid k=%0d: got %b expected %b", k, instr_valid_o, (occ_m > 0)); end
      if (instr_valid_o && instr_ready_i && !redirect_i) begin
        pops++;
        n_checks++; if (instr_pc_o !== exp_pc || instr_o !== mem_data(exp_pc)) begin n_errors++; $display("FAIL rnd_out k=%0d: got pc=%h ins=%h expected pc=%h ins=%h", k, instr_pc_o, instr_o, exp_pc, mem_data(exp_pc)); end
      end
      if (imem_req_o) begin
        n_checks++; if (imem_addr_o !== exp_fetch) begin n_errors++; $display("FAIL rnd_addr k=%0d: got %h expected %h", k, imem_addr_o, exp_fetch); end
      end
      if (held && !redirect_i) begin
        n_checks++; if (imem_req_o !== 1'b1) begin n_errors++; $display("FAIL rnd_req_stable k=%0d: got %b expected 1", k, imem_req_o); end
      end
      n_checks++; if (mq_addr.size() + occ_m > DEPTH) begin n_errors++; $display("FAIL rnd_credit k=%0d: got %0d expected <= %0d", k, mq_addr.size() + occ_m, DEPTH); end
      n_checks++; if (fetch_fault_o !== 1'b0) begin n_errors++; $display("FAIL rnd_fault k=%0d: got %b expected 0", k, fetch_fault_o); end
      held = imem_req_o && !imem_gnt_i;
      cycle_post();
    end
    n_checks++; if (pops < 200) begin n_errors++; $display("FAIL rnd_progress: got %0d pops expected >= 200", pops); end
  endtask

  initial begin
    cyc = 0;
    test_reset();
    test_stream();
    test_backpressure();
    test_gnt_stall();
    test_redirect_drain();
    test_redirect_same_cycle();
    test_misalign();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/instr_fetch.md
# instr_fetch

Fetch stage directly downstream of the program counter in the RISC-V core. Holds its own fetch address, issues in-order word requests to instruction memory over a req/gnt/rvalid handshake, and buffers returned instructions with their PCs in a small FIFO. Decode consumes the FIFO over a valid/ready handshake. A redirect from execute flushes buffered and in-flight instructions and restarts fetch at the target.

## Interface
Parameters:
- DEPTH, 2, FIFO entries; also the maximum number of outstanding memory requests.
- RESET_PC, 32'h00000000, first fetch address after reset.

Ports:
- clk  in  1  clock; all logic on the rising edge
- reset  in  1  synchronous, active-low reset; sampled only on rising edge of clk
- redirect_i  in  1  flush and restart fetch at redirect_pc_i
- redirect_pc_i  in  32  restart address
- imem_req_o  out  1  memory request valid
- imem_addr_o  out  32  request word address
- imem_gnt_i  in  1  request accepted this cycle
- imem_rvalid_i  in  1  response valid; responses return in request order
- imem_rdata_i  in  32  response instruction word
- instr_valid_o  out  1  FIFO head valid
- instr_o  out  32  FIFO head instruction
- instr_pc_o  out  32  PC of instr_o
- instr_ready_i  in  1  decode accepts head
- fetch_fault_o  out  1  misaligned-redirect fault (see Configuration)

## Operation
- Credit rule: issue a request only while occupancy + outstanding < DEPTH; FIFO never overflows.
- imem_req_o and imem_addr_o stay stable until imem_gnt_i; on grant fetch_addr += 4 (32-bit wrap, 32'hFFFFFFFC -> 0).
- Response PC tracked by resp_pc: set to the target on redirect, +4 per accepted (non-discarded) response; pushed with the data.
- FSM states:
  - RUN: normal issue.
  - DRAIN: entered on redirect while outstanding > 0, or if imem_gnt_i is high in the redirect cycle. discard_cnt loads the count of in-flight requests. Each rvalid decrements it and is dropped, with no push. No requests are issued. Returns to RUN when discard_cnt reaches 0.
- Redirect cycle:
  - FIFO cleared.
  - fetch_addr and resp_pc loaded with redirect_pc_i.
  - imem_req_o forced low.
  - A same-cycle pop is ignored; a same-cycle rvalid counts as discarded.
- Redirect during DRAIN: new target replaces the old one. discard_cnt adds any same-cycle grant and subtracts any same-cycle rvalid.
- Push and pop in the same cycle are permitted at any occupancy.
- Reset mid-operation: all state cleared. Responses to pre-reset requests are an environment violation.

## Timing
- Reset values:
  - imem_req_o 0, imem_addr_o RESET_PC.
  - instr_valid_o 0, instr_o 0, instr_pc_o 0, fetch_fault_o 0.
  - Internal: FIFO empty, outstanding 0, state RUN.
- imem_req_o asserts the first cycle after reset deasserts.
- rvalid in cycle N -> instr_valid_o in N+1 (registered FIFO output).
- Redirect in cycle T with nothing outstanding: imem_req_o high at T+1 with the target address. With 1-cycle memory, instr_valid_o rises at T+3.
- Full throughput with single-cycle memory and DEPTH=2: one instruction per cycle.

## Configuration
- IF_MISALIGN_CHECK_EN defined:
  - A redirect with redirect_pc_i[1:0] != 0 sets fetch_fault_o the next cycle.
  - fetch_fault_o stays high, and no requests are issued, until an aligned redirect or reset.
  - The fault itself has instr_valid_o low.
- IF_MISALIGN_CHECK_EN undefined:
  - redirect_pc_i[1:0] ignored and treated as 00.
  - fetch_fault_o tied 0.

## Structure
- Shared package riscv_pkg:
  - XLEN = 32
  - PC_STEP = 32'h4
  - NOP_INSTR = 32'h00000013
  - Enum fetch_state_t {RUN, DRAIN}
- Sub-module fetch_fifo: synchronous DEPTH-entry FIFO of {pc, instr}; flush input; registered head outputs.
- Credit and discard counters and the FSM live in instr_fetch.

## Test plan
- Reset released, gnt always 1, 1-cycle rvalid, ready=1 -> addresses 0,4,8,...; instr_pc_o 0,4,8 back-to-back from the 3rd cycle.
- ready=0 for 10 cycles -> at most 2 requests granted, FIFO holds PC 0 and 4, no further req; ready=1 -> drains in order, fetch resumes at 8.
- gnt held 0 for 5 cycles -> imem_addr_o constant; grant on cycle 6 -> address advances by exactly 4.
- Two requests outstanding (0x10, 0x14), redirect to 0x100 -> both responses dropped, no req until second rvalid, then req 0x100; first instr_pc_o = 0x100.
- Redirect and rvalid and ready in the same cycle, FIFO holding one entry -> FIFO empty next cycle, rvalid discarded, no pop observed.
- With IF_MISALIGN_CHECK_EN, redirect to 0x102 -> fetch_fault_o=1, imem_req_o=0; redirect to 0x200 -> fault clears, fetch at 0x200.
